// File: rtl/feeder_pkg.sv
// Shared types and widths for the instruction feeder.
package feeder_pkg;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAITLO, WAITHI, DONE, ABORT
  } feeder_state_t;
endpackage

// File: rtl/instr_feeder_if.sv
// Host push channel plus the cpu in/load/s/w/out/NVZ bundle.
interface instr_feeder_if;
  import feeder_pkg::*;

  logic               push_valid;
  logic               push_ready;
  logic [INSTR_W-1:0] push_data;
  logic [INSTR_W-1:0] cpu_in;
  logic               cpu_load;
  logic               cpu_s;
  logic               cpu_w;
  logic [INSTR_W-1:0] cpu_out;
  logic               cpu_N;
  logic               cpu_V;
  logic               cpu_Z;

  // feeder side
  modport slave (
    input  push_valid, push_data, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
    output push_ready, cpu_in, cpu_load, cpu_s
  );

  // host + cpu side
  modport master (
    output push_valid, push_data, cpu_w, cpu_out, cpu_N, cpu_V, cpu_Z,
    input  push_ready, cpu_in, cpu_load, cpu_s
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered storage; pointers wrap modulo DEPTH.
module instr_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  // A push at full only lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Storage: no reset needed, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instr_feeder.sv
// Buffers host instructions and issues them one at a time to the cpu,
// recording out/NVZ and a cycle count for each completed instruction.
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int CW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_feeder_if.slave          bus,
  output logic                   res_valid,
  output logic [INSTR_W-1:0]     res_data,
  output logic [2:0]             res_nvz,
  output logic [CW-1:0]          res_cycles,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err_timeout
);
  feeder_state_t      state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [INSTR_W-1:0] issue, head;
  logic               full, empty, pop, push, at_limit;

  // Head leaves only on IDLE->LOAD, and only when the cpu is waiting.
  assign pop      = (state == IDLE) && !empty && bus.cpu_w;
  // Ready also covers the full-with-pop case so that push+pop at full
  // is a real handshake.
  assign bus.push_ready = !full || pop;
  assign push     = bus.push_valid && bus.push_ready;
  assign at_limit = (cnt == CW'(TIMEOUT));

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.push_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // cpu controls decode only the state register: no path from cpu_w.
  assign bus.cpu_in   = issue;
  assign bus.cpu_load = (state == LOAD);
  assign bus.cpu_s    = (state == START);
  assign busy         = (state != IDLE);

  // Next-state logic; completion wins over timeout on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = WAITLO;
      WAITLO:  if (!bus.cpu_w) state_nxt = WAITHI;
               else if (at_limit) state_nxt = ABORT;
      WAITHI:  if (bus.cpu_w) state_nxt = DONE;
               else if (at_limit) state_nxt = ABORT;
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue register: holds the last popped word for cpu_in.
  always_ff @(posedge clk) begin
    if (reset)    issue <= '0;
    else if (pop) issue <= head;
  end

  // Cycle counter: START counts as 1, saturating while waiting.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (state == START) cnt <= CW'(1);
    else if ((state == WAITLO || state == WAITHI) && cnt != '1) cnt <= cnt + 1'b1;
  end

  // Result record: captured on DONE, held until the next DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_nvz    <= '0;
      res_cycles <= '0;
    end else begin
      res_valid <= (state == DONE);
      if (state == DONE) begin
        res_data   <= bus.cpu_out;
        res_nvz    <= {bus.cpu_N, bus.cpu_V, bus.cpu_Z};
        res_cycles <= cnt;
      end
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset)               err_timeout <= 1'b0;
    else if (state == ABORT) err_timeout <= 1'b1;
  end
endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench: scoreboard of expected issues/results plus a small cpu model.
module tb_instr_feeder;
  import feeder_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] data;
    logic [2:0]  nvz;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        res_valid, busy, err_timeout;
  logic [15:0] res_data;
  logic [2:0]  res_nvz;
  logic [7:0]  res_cycles;
  logic [3:0]  level;

  instr_feeder_if bus_if ();

  instr_feeder #(.DEPTH(8), .CW(8), .TIMEOUT(200)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_nvz     (res_nvz),
    .res_cycles  (res_cycles),
    .busy        (busy),
    .level       (level),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  exp_t exp_q[$];
  exp_t res_q[$];

  // cpu model knobs
  int          lat = 3;
  bit          hang = 0, stall = 0, ovr = 0;
  logic [15:0] ovr_out = '0;
  logic [2:0]  ovr_nvz = '0;
  logic        w_reg;
  int          rem;
  logic [15:0] m_instr;

  always @(posedge clk) cyc <= cyc + 1;

  // cpu model: w drops after s, stays low lat cycles, then rises with a result.
  assign bus_if.cpu_w = w_reg & ~stall;
  always @(posedge clk) begin
    if (reset) begin
      w_reg <= 1'b1;
      rem <= 0;
      m_instr <= '0;
      bus_if.cpu_out <= '0;
      {bus_if.cpu_N, bus_if.cpu_V, bus_if.cpu_Z} <= 3'b000;
    end else begin
      if (bus_if.cpu_load) m_instr <= bus_if.cpu_in;
      if (bus_if.cpu_s) begin
        w_reg <= 1'b0;
        rem <= lat - 1;
      end else if (!w_reg) begin
        if (rem > 0) rem <= rem - 1;
        else if (!hang) begin
          w_reg <= 1'b1;
          bus_if.cpu_out <= ovr ? ovr_out : (m_instr ^ 16'h5A5A);
          {bus_if.cpu_N, bus_if.cpu_V, bus_if.cpu_Z} <= ovr ? ovr_nvz : m_instr[2:0];
        end
      end
    end
  end

  function automatic exp_t mk(input logic [15:0] w);
    exp_t e;
    e.instr = w; e.data = w ^ 16'h5A5A; e.nvz = w[2:0]; e.cycles = lat + 2;
    return e;
  endfunction

  // Monitor: issue order, load/s pulse shape, result records, issue gaps.
  bit   prev_load = 0, gap_chk = 0;
  int   last_res = -1, s_cyc = 0, res_cnt = 0;
  exp_t me;
  initial forever begin
    @(negedge clk);
    if (reset) prev_load = 0;
    else begin
      n_chk++;
      if (bus_if.cpu_s !== prev_load) begin
        n_fail++; $display("FAIL s_after_load: cpu_s=%b expected %b at cyc %0d", bus_if.cpu_s, prev_load, cyc);
      end
      if (bus_if.cpu_s) s_cyc = cyc;
      if (bus_if.cpu_load) begin
        n_chk++;
        if (prev_load) begin
          n_fail++; $display("FAIL load_width: cpu_load high two cycles at cyc %0d", cyc);
        end
        if (gap_chk && last_res >= 0) begin
          n_chk++;
          if (cyc - last_res != 1) begin
            n_fail++; $display("FAIL issue_gap: %0d cycles from res_valid to load, expected 1", cyc - last_res);
          end
        end
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_load: cpu_in=%h with nothing queued", bus_if.cpu_in);
        end else begin
          me = exp_q.pop_front();
          if (bus_if.cpu_in !== me.instr) begin
            n_fail++; $display("FAIL issue_order: cpu_in=%h expected %h", bus_if.cpu_in, me.instr);
          end
          res_q.push_back(me);
        end
      end
      if (res_valid) begin
        res_cnt++;
        last_res = cyc;
        n_chk++;
        if (res_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_result: res_data=%h", res_data);
        end else begin
          me = res_q.pop_front();
          if (res_data !== me.data || res_nvz !== me.nvz || res_cycles !== 8'(me.cycles)) begin
            n_fail++;
            $display("FAIL result: data=%h nvz=%b cycles=%0d expected data=%h nvz=%b cycles=%0d",
                     res_data, res_nvz, res_cycles, me.data, me.nvz, me.cycles);
          end
        end
      end
      prev_load = bus_if.cpu_load;
    end
  end

  task automatic push_one(input logic [15:0] w, input bit expect_acc);
    @(negedge clk);
    bus_if.push_valid = 1'b1;
    bus_if.push_data = w;
    if (expect_acc) exp_q.push_back(mk(w));
  endtask

  task automatic push_end();
    @(negedge clk);
    bus_if.push_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0 || busy || level != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++; $display("FAIL %s_drain: timed out, exp_q=%0d res_q=%0d", name, exp_q.size(), res_q.size());
    end
  endtask

  task automatic test_reset();
    bus_if.push_valid = 1'b0; bus_if.push_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({res_valid, res_data, res_nvz, res_cycles, busy, level, err_timeout} !== '0 ||
        {bus_if.cpu_load, bus_if.cpu_s, bus_if.cpu_in} !== '0 || bus_if.push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rv=%b data=%h nvz=%b cyc=%0d busy=%b level=%0d err=%b load=%b s=%b in=%h ready=%b expected zeros and ready=1",
               res_valid, res_data, res_nvz, res_cycles, busy, level, err_timeout,
               bus_if.cpu_load, bus_if.cpu_s, bus_if.cpu_in, bus_if.push_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int r0 = res_cnt;
    lat = 3;
    push_one(16'hD007, 1);
    push_end();
    wait_drain("single", 100);
    n_chk++;
    if (res_cnt - r0 != 1) begin
      n_fail++; $display("FAIL single_count: %0d results, expected 1", res_cnt - r0);
    end
    n_chk++;
    if (res_cycles !== 8'd5 || res_data !== 16'h8A5D) begin
      n_fail++; $display("FAIL single_record: cycles=%0d data=%h expected 5 and 8a5d", res_cycles, res_data);
    end
  endtask

  task automatic test_back_to_back();
    int r0 = res_cnt;
    logic [15:0] words [4] = '{16'hA101, 16'hB202, 16'hC303, 16'hE404};
    lat = 2;
    gap_chk = 1; last_res = -1;
    for (int i = 0; i < 4; i++) push_one(words[i], 1);
    push_end();
    #1;
    n_chk++;
    if (level !== 4'd3) begin
      n_fail++; $display("FAIL b2b_level: level=%0d expected 3", level);
    end
    wait_drain("b2b", 200);
    gap_chk = 0;
    n_chk++;
    if (res_cnt - r0 != 4 || level !== 4'd0) begin
      n_fail++; $display("FAIL b2b_count: results=%0d level=%0d expected 4 and 0", res_cnt - r0, level);
    end
    lat = 3;
  endtask

  task automatic test_full();
    @(negedge clk);
    stall = 1;
    for (int i = 0; i < 8; i++) push_one(16'h1000 + 16'(i), 1);
    push_end();
    #1;
    n_chk++;
    if (level !== 4'd8 || bus_if.push_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_level: level=%0d ready=%b expected 8 and 0", level, bus_if.push_ready);
    end
    push_one(16'hBAD0, 0);
    push_end();
    #1;
    n_chk++;
    if (level !== 4'd8) begin
      n_fail++; $display("FAIL full_drop: level=%0d expected 8", level);
    end
    @(negedge clk);
    stall = 0;
    bus_if.push_valid = 1'b1; bus_if.push_data = 16'h2009;
    exp_q.push_back(mk(16'h2009));
    #1;
    n_chk++;
    if (bus_if.push_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_pushpop_ready: ready=%b expected 1", bus_if.push_ready);
    end
    push_end();
    #1;
    n_chk++;
    if (level !== 4'd8) begin
      n_fail++; $display("FAIL full_pushpop_level: level=%0d expected 8", level);
    end
    wait_drain("full", 600);
  endtask

  task automatic test_timeout();
    int r0 = res_cnt, n = 0;
    hang = 1;
    push_one(16'h7777, 1);
    push_one(16'h3131, 1);
    push_end();
    while (!err_timeout && n < 400) begin @(negedge clk); n++; end
    n_chk++;
    if (!err_timeout) begin
      n_fail++; $display("FAIL timeout_flag: err_timeout=%b expected 1", err_timeout);
    end else begin
      n_chk++;
      if (cyc - s_cyc != 202) begin
        n_fail++; $display("FAIL timeout_time: flag %0d cycles after s, expected 202", cyc - s_cyc);
      end
    end
    n_chk++;
    if (res_cnt != r0 || level !== 4'd1) begin
      n_fail++; $display("FAIL timeout_nores: results=%0d level=%0d expected 0 and 1", res_cnt - r0, level);
    end
    if (res_q.size() != 0) void'(res_q.pop_front());
    hang = 0;
    wait_drain("timeout", 100);
    n_chk++;
    if (err_timeout !== 1'b1 || res_cnt - r0 != 1) begin
      n_fail++; $display("FAIL timeout_after: err=%b results=%0d expected 1 and 1", err_timeout, res_cnt - r0);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    hang = 1;
    for (int i = 0; i < 4; i++) push_one(16'h4400 + 16'(i), 1);
    push_end();
    while (!(level == 4'd3 && !bus_if.cpu_w && busy) && n < 50) begin @(negedge clk); n++; end
    n_chk++;
    if (n >= 50) begin
      n_fail++; $display("FAIL midrst_setup: level=%0d w=%b busy=%b", level, bus_if.cpu_w, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || level !== 4'd0 || err_timeout !== 1'b0 || res_valid !== 1'b0 ||
        bus_if.cpu_load !== 1'b0 || bus_if.cpu_s !== 1'b0 || bus_if.push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: busy=%b level=%0d err=%b rv=%b load=%b s=%b ready=%b expected 0,0,0,0,0,0,1",
               busy, level, err_timeout, res_valid, bus_if.cpu_load, bus_if.cpu_s, bus_if.push_ready);
    end
    reset = 1'b0;
    hang = 0;
    exp_q.delete();
    res_q.delete();
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || level !== 4'd0) begin
      n_fail++; $display("FAIL midrst_quiet: busy=%b level=%0d expected 0 and 0", busy, level);
    end
  endtask

  task automatic test_flags();
    exp_t e;
    ovr = 1; ovr_out = 16'h8000; ovr_nvz = 3'b100;
    e.instr = 16'h6123; e.data = 16'h8000; e.nvz = 3'b100; e.cycles = 5;
    @(negedge clk);
    bus_if.push_valid = 1'b1; bus_if.push_data = 16'h6123;
    exp_q.push_back(e);
    push_end();
    wait_drain("flags", 100);
    n_chk++;
    if (res_data !== 16'h8000 || res_nvz !== 3'b100) begin
      n_fail++; $display("FAIL flags_record: data=%h nvz=%b expected 8000 and 100", res_data, res_nvz);
    end
    ovr = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_timeout();
    test_mid_reset();
    test_flags();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
